// File: rtl/sobel_row_sequencer_if.sv
// Row memory read port and filtered-row output stream of the Sobel row sequencer.
// master = sequencer side, slave = memory/array/downstream side.
interface sobel_row_sequencer_if #(
    parameter int ROW_AW = 10
);
    logic              mem_rd_en;
    logic [ROW_AW-1:0] mem_rd_addr;
    logic              array_load;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_AW-1:0] out_row;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        output array_load,
        output out_valid,
        output out_row,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        input  array_load,
        input  out_valid,
        input  out_row,
        output out_ready
    );
endinterface

// File: rtl/sobel_row_sequencer.sv
// Frame controller for sobel_filter_scalable: reads rows, strobes them into the
// array, waits out the array latency and hands each centre row downstream.
module sobel_row_sequencer #(
    parameter int ROW_AW   = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ROW_AW-1:0] img_rows,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    sobel_row_sequencer_if.master bus
);

    localparam int WW = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        SETTLE,
        EMIT,
        DONE
    } state_t;

    state_t            state;
    logic [ROW_AW-1:0] row_cnt;
    logic [ROW_AW-1:0] img_q;
    logic [WW-1:0]     wait_cnt;

    logic              busy_q;
    logic              done_q;
    logic              cfg_err_q;
    logic              rd_en_q;
    logic [ROW_AW-1:0] rd_addr_q;
    logic              load_q;
    logic              out_valid_q;
    logic [ROW_AW-1:0] out_row_q;

    assign busy            = busy_q;
    assign done            = done_q;
    assign cfg_err         = cfg_err_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.array_load  = load_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_row     = out_row_q;

    // Outputs are registered together with the state they belong to, so every
    // transition below also loads the strobes seen during the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row_cnt     <= '0;
            img_q       <= '0;
            wait_cnt    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            load_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            rd_en_q   <= 1'b0;
            load_q    <= 1'b0;

            if (abort && state != IDLE) begin
                state       <= IDLE;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (img_rows >= ROW_AW'(3)) begin
                                img_q     <= img_rows;
                                row_cnt   <= '0;
                                state     <= READ;
                                busy_q    <= 1'b1;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= '0;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end

                    READ: begin
                        state  <= LOAD;
                        load_q <= 1'b1;
                    end

                    LOAD: begin
                        if (row_cnt < ROW_AW'(2)) begin
                            row_cnt   <= row_cnt + ROW_AW'(1);
                            state     <= READ;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= row_cnt + ROW_AW'(1);
                        end else if (PIPE_LAT == 0) begin
                            state       <= EMIT;
                            out_valid_q <= 1'b1;
                            out_row_q   <= row_cnt - ROW_AW'(1);
                        end else begin
                            state    <= SETTLE;
                            wait_cnt <= WW'(PIPE_LAT);
                        end
                    end

                    SETTLE: begin
                        if (wait_cnt <= WW'(1)) begin
                            state       <= EMIT;
                            out_valid_q <= 1'b1;
                            out_row_q   <= row_cnt - ROW_AW'(1);
                        end else begin
                            wait_cnt <= wait_cnt - WW'(1);
                        end
                    end

                    EMIT: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            if (row_cnt == img_q - ROW_AW'(1)) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                row_cnt   <= row_cnt + ROW_AW'(1);
                                state     <= READ;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= row_cnt + ROW_AW'(1);
                            end
                        end
                    end

                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end

                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sobel_row_sequencer.sv
// Bench for sobel_row_sequencer: timeline reference model, directed and random
// frames on a PIPE_LAT=2 instance and a PIPE_LAT=0 instance.
module tb_sobel_row_sequencer;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start_a = 1'b0;
    logic          start_b = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b1;
    logic [AW-1:0] img_rows = '0;

    logic busy_a, done_a, cfg_a;
    logic busy_b, done_b, cfg_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    sobel_row_sequencer_if #(.ROW_AW(AW)) ifa ();
    sobel_row_sequencer_if #(.ROW_AW(AW)) ifb ();

    assign ifa.out_ready = ready;
    assign ifb.out_ready = ready;

    sobel_row_sequencer #(.ROW_AW(AW), .PIPE_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .img_rows(img_rows), .busy(busy_a), .done(done_a),
        .cfg_err(cfg_a), .bus(ifa)
    );

    sobel_row_sequencer #(.ROW_AW(AW), .PIPE_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .img_rows(img_rows), .busy(busy_b), .done(done_b),
        .cfg_err(cfg_b), .bus(ifb)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Expected behaviour is a timeline: row k is read at cycle rdc and loaded
    // at rdc+1; priming rows chain every 2 cycles; output rows appear P+2
    // cycles after their read and the next read follows the handshake.
    // term_mode: 1 = abort in first SETTLE cycle of row term_k,
    //            2 = rst in first EMIT cycle of row term_k.
    // rmode: 0 ready high, 1 random ready, 2 7-cycle stall on first output.
    task automatic frame(input bit sel, input int n, input int p,
                         input int rmode, input int term_mode,
                         input int term_k, input bit junk,
                         input bit idle_abort);
        int k, rdc, donec, termc;
        bit e_rd, e_ld, e_ov, e_busy, e_done, hs;
        int o_rd, o_ld, o_ov, o_busy, o_done, o_cfg, o_addr, o_row;
        img_rows = AW'(n);
        abort = idle_abort;
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        k = 0;
        rdc = 1;
        donec = -1;
        termc = -1;
        for (int c = 1; c < 20000; c++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
            abort = 1'b0;
            rst = 1'b0;
            o_rd   = int'(sel ? ifb.mem_rd_en   : ifa.mem_rd_en);
            o_ld   = int'(sel ? ifb.array_load  : ifa.array_load);
            o_ov   = int'(sel ? ifb.out_valid   : ifa.out_valid);
            o_addr = int'(sel ? ifb.mem_rd_addr : ifa.mem_rd_addr);
            o_row  = int'(sel ? ifb.out_row     : ifa.out_row);
            o_busy = int'(sel ? busy_b : busy_a);
            o_done = int'(sel ? done_b : done_a);
            o_cfg  = int'(sel ? cfg_b  : cfg_a);

            if (n < 3) begin
                chk("cfg_err_pulse", o_cfg, 1);
                chk("cfg_busy", o_busy, 0);
                chk("cfg_rd", o_rd, 0);
                @(posedge clk);
                #1;
                chk("cfg_err_drop", int'(sel ? cfg_b : cfg_a), 0);
                chk("cfg_busy2", int'(sel ? busy_b : busy_a), 0);
                return;
            end

            if (termc >= 0) begin
                chk("term_busy", o_busy, 0);
                chk("term_rd", o_rd, 0);
                chk("term_ld", o_ld, 0);
                chk("term_ov", o_ov, 0);
                chk("term_done", o_done, 0);
                if (term_mode == 2) begin
                    chk("rst_addr", o_addr, 0);
                    chk("rst_row", o_row, 0);
                end
                return;
            end

            e_rd   = (donec < 0) && (c == rdc);
            e_ld   = (donec < 0) && (c == rdc + 1);
            e_ov   = (donec < 0) && (k >= 2) && (c >= rdc + 2 + p);
            e_done = (c == donec);
            e_busy = (donec < 0) || (c <= donec);

            chk("mem_rd_en", o_rd, int'(e_rd));
            chk("array_load", o_ld, int'(e_ld));
            chk("out_valid", o_ov, int'(e_ov));
            chk("busy", o_busy, int'(e_busy));
            chk("done", o_done, int'(e_done));
            chk("cfg_err", o_cfg, 0);
            if (e_rd) chk("mem_rd_addr", o_addr, k);
            if (e_ov) chk("out_row", o_row, k - 1);

            if (donec >= 0 && c == donec + 1) return;

            unique case (rmode)
                0: ready = 1'b1;
                1: ready = ($urandom_range(0, 99) < 55);
                default: ready = !(k == 2 && c < rdc + 2 + p + 7);
            endcase
            if (e_busy) img_rows = AW'($urandom);
            if (junk && (c % 3 == 0)) begin
                if (sel) start_b = 1'b1;
                else start_a = 1'b1;
            end
            if (term_mode == 1 && k == term_k && c == rdc + 2) begin
                abort = 1'b1;
                termc = c;
            end
            if (term_mode == 2 && k == term_k && c == rdc + 2 + p) begin
                rst = 1'b1;
                termc = c;
            end

            if (termc < 0) begin
                hs = e_ov && ready;
                if (hs) begin
                    if (k == n - 1) donec = c + 1;
                    else begin
                        k++;
                        rdc = c + 1;
                    end
                end else if (k < 2 && c == rdc + 1) begin
                    k++;
                    rdc = c + 1;
                end
            end
        end
        chk("timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b1;
        img_rows = AW'(4);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_cfg", int'(cfg_a), 0);
        chk("rst_rd", int'(ifa.mem_rd_en), 0);
        chk("rst_ld", int'(ifa.array_load), 0);
        chk("rst_ov", int'(ifa.out_valid), 0);
        chk("rst_addr", int'(ifa.mem_rd_addr), 0);
        chk("rst_row", int'(ifa.out_row), 0);
        chk("rst_b_busy", int'(busy_b), 0);
        chk("rst_b_ov", int'(ifb.out_valid), 0);
        rst = 1'b0;
        start_a = 1'b0;
        @(posedge clk);
        #1;

        frame(0, 4, 2, 0, 0, 0, 0, 0);
        frame(0, 5, 2, 2, 0, 0, 0, 0);
        frame(0, 2, 2, 0, 0, 0, 0, 0);
        frame(0, 3, 2, 0, 0, 0, 0, 0);
        frame(0, 5, 2, 1, 1, 3, 0, 0);
        frame(0, 4, 2, 0, 0, 0, 0, 0);
        frame(0, 5, 2, 1, 2, 2, 0, 0);
        frame(0, 6, 2, 0, 0, 0, 1, 0);
        frame(0, 4, 2, 1, 0, 0, 0, 1);
        frame(0, 1, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            frame(0, 3 + int'($urandom_range(0, 9)), 2, 1, 0, 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        frame(1, 1023, 0, 0, 0, 0, 0, 0);
        frame(1, 5, 0, 1, 0, 0, 1, 0);
        frame(1, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
